// File: rtl/mont_pkg.sv
// Shared constants for the Montgomery multiplier operand path.
// Holds the select codes and the default operand width.
package mont_pkg;

    localparam int WIDTH_DEF = 1027;

    localparam logic [2:0] SEL_ZERO = 3'b000;
    localparam logic [2:0] SEL_M    = 3'b001;
    localparam logic [2:0] SEL_2M   = 3'b010;
    localparam logic [2:0] SEL_3M   = 3'b011;
    localparam logic [2:0] SEL_B    = 3'b100;
    localparam logic [2:0] SEL_2B   = 3'b101;
    localparam logic [2:0] SEL_3B   = 3'b110;
    localparam logic [2:0] SEL_RSVD = 3'b111;

endpackage

// File: rtl/seven_multiplexer.sv
// Registered 7-way operand selector feeding the accumulator adder.
// SEVEN_MUX_SEL_ERR_EN adds a registered sel_err flag for the reserved code.
module seven_multiplexer
    import mont_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] in_M,
    input  logic [WIDTH-1:0] in_2M,
    input  logic [WIDTH-1:0] in_3M,
    input  logic [WIDTH-1:0] in_B,
    input  logic [WIDTH-1:0] in_2B,
    input  logic [WIDTH-1:0] in_3B,
    input  logic [2:0]       select,
    output logic [WIDTH-1:0] out
`ifdef SEVEN_MUX_SEL_ERR_EN
    ,
    output logic             sel_err
`endif
);

    logic [WIDTH-1:0] nxt;

    // Codes 000 and 111 both fall through to zero.
    always_comb begin
        nxt = '0;
        unique case (1'b1)
            (select == SEL_M):  nxt = in_M;
            (select == SEL_2M): nxt = in_2M;
            (select == SEL_3M): nxt = in_3M;
            (select == SEL_B):  nxt = in_B;
            (select == SEL_2B): nxt = in_2B;
            (select == SEL_3B): nxt = in_3B;
            default:            nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out <= '0;
        end else begin
            out <= nxt;
        end
    end

`ifdef SEVEN_MUX_SEL_ERR_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sel_err <= 1'b0;
        end else begin
            sel_err <= (select == SEL_RSVD);
        end
    end
`endif

endmodule

// File: tb/tb_seven_multiplexer.sv
// Randomized self-checking bench for seven_multiplexer against a lookup-table model.
// Also covers the directed reset, sweep, width and input-follow cases.
module tb_seven_multiplexer;

    localparam int W = 1027;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [W-1:0] in_M, in_2M, in_3M, in_B, in_2B, in_3B;
    logic [2:0]   select = 3'd0;
    logic [W-1:0] out;
`ifdef SEVEN_MUX_SEL_ERR_EN
    logic         sel_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_out = '0;
    logic         exp_err = 1'b0;
    logic         model_on = 1'b0;

    seven_multiplexer #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .in_M   (in_M),
        .in_2M  (in_2M),
        .in_3M  (in_3M),
        .in_B   (in_B),
        .in_2B  (in_2B),
        .in_3B  (in_3B),
        .select (select),
        .out    (out)
`ifdef SEVEN_MUX_SEL_ERR_EN
        ,
        .sel_err(sel_err)
`endif
    );

    always #5 clk = ~clk;

    // Table view of the selector: index = code, entries 0 and 7 are zero.
    function automatic logic [W-1:0] pick(input logic [2:0] s);
        logic [W-1:0] tbl [8];
        tbl[0] = '0;
        tbl[1] = in_M;
        tbl[2] = in_2M;
        tbl[3] = in_3M;
        tbl[4] = in_B;
        tbl[5] = in_2B;
        tbl[6] = in_3B;
        tbl[7] = '0;
        return tbl[s];
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            exp_out <= '0;
            exp_err <= 1'b0;
        end else begin
            exp_out <= pick(select);
            exp_err <= (select == 3'd7);
        end
    end

    always @(negedge resetn) begin
        exp_out = '0;
        exp_err = 1'b0;
    end

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s act hi=%h lo=%h req hi=%h lo=%h", nm,
                     act[W-1 -: 64], act[127:0], req[W-1 -: 64], req[127:0]);
        end
    endtask

    task automatic chk_bit(input string nm, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s act=%b req=%b", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            chk("model_out", out, exp_out);
`ifdef SEVEN_MUX_SEL_ERR_EN
            chk_bit("model_err", sel_err, exp_err);
`endif
        end
    end

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = 1'($urandom_range(1, 0));
        return v;
    endfunction

    task automatic set_small();
        in_M  = W'(1);
        in_2M = W'(2);
        in_3M = W'(3);
        in_B  = W'(4);
        in_2B = W'(5);
        in_3B = W'(6);
    endtask

    // Drive at negedge, let one rising edge sample, land on the next negedge.
    task automatic step(input logic [2:0] s);
        select = s;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    logic [W-1:0] ones;
    logic [W-1:0] top;

    initial begin
        set_small();
        ones = '1;
        top = '0;
        top[W-1] = 1'b1;

        // Reset holds out at zero across edges.
        resetn = 1'b0;
        select = 3'd1;
        #1;
        chk("reset_now", out, '0);
        @(negedge clk);
        chk("reset_e1", out, '0);
        @(negedge clk);
        chk("reset_e2", out, '0);
        resetn = 1'b1;
        model_on = 1'b1;
        @(negedge clk);
        #1;
        chk("release_load", out, W'(1));

        for (int k = 1; k <= 6; k++) begin
            step(3'(k));
            chk("sweep", out, W'(k));
        end

        step(3'd0);
        chk("sel_zero", out, '0);
        step(3'd7);
        chk("sel_rsvd", out, '0);
`ifdef SEVEN_MUX_SEL_ERR_EN
        chk_bit("err_set", sel_err, 1'b1);
`endif
        step(3'd1);
`ifdef SEVEN_MUX_SEL_ERR_EN
        chk_bit("err_clear", sel_err, 1'b0);
`endif

        // Asynchronous clear between edges.
        step(3'd3);
        chk("hold_3m", out, W'(3));
        resetn = 1'b0;
        #1;
        chk("async_clear", out, '0);
        @(negedge clk);
        chk("async_hold", out, '0);
        resetn = 1'b1;
        step(3'd3);
        chk("after_async", out, W'(3));

        in_3B = ones;
        in_B = top;
        step(3'd6);
        chk("wide_ones", out, ones);
        step(3'd4);
        chk("wide_top", out, top);

        set_small();
        step(3'd2);
        chk("follow_pre", out, W'(2));
        in_2M = W'(7);
        step(3'd2);
        chk("follow_post", out, W'(7));

        for (int n = 0; n < 300; n++) begin
            in_M  = rand_w();
            in_2M = rand_w();
            in_3M = rand_w();
            in_B  = rand_w();
            in_2B = rand_w();
            in_3B = rand_w();
            if ($urandom_range(39, 0) == 0) begin
                resetn = 1'b0;
                #2;
                resetn = 1'b1;
            end
            step(3'($urandom_range(7, 0)));
        end

        model_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
